miriscv_pipeline_cu: RTL and testbench

Pipeline control unit for the miriscv in-order core.
- Generates cu_stall_f, cu_stall_d, cu_kill_f and cu_kill_d for the fetch and decode stages.
- Keeps a per-GPR scoreboard of in-flight writes to detect RAW hazards. There is no forwarding.
- Flushes the front end on an execute-stage redirect and drains the pipeline for FENCE.

---
 rtl/miriscv_pipeline_cu.sv | 162 ++++++++++++++++
 tb/tb_miriscv_pipeline_cu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/miriscv_pipeline_cu.sv
// Pipeline control unit: per-GPR pending-write scoreboard, RAW/saturation stalls,
// redirect kills and FENCE drain. Optional perf counters under MIRISCV_CU_PERF_CNT_EN.

module miriscv_cu_pend_cnt #(
    parameter int unsigned PEND_CNT_W = 2
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  inc,
    input  logic                  dec_wb,
    input  logic                  dec_kill,
    output logic [PEND_CNT_W-1:0] cnt
);
    logic [PEND_CNT_W:0] up;
    logic [PEND_CNT_W:0] dn;

    assign up = {1'b0, cnt} + {{PEND_CNT_W{1'b0}}, inc};
    assign dn = {{PEND_CNT_W{1'b0}}, dec_wb} + {{PEND_CNT_W{1'b0}}, dec_kill};

    // A decrement below zero is dropped rather than wrapping
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)     cnt <= '0;
        else if (dn > up) cnt <= '0;
        else              cnt <= PEND_CNT_W'(up - dn);
    end

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!arstn_i) dn <= up);
`endif
endmodule

module miriscv_pipeline_cu #(
    parameter int unsigned PEND_CNT_W = 2,
    parameter int unsigned GPR_NUM    = 32
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        f_valid_i,
    input  logic [4:0]  f_cu_rs1_addr_i,
    input  logic        f_cu_rs1_req_i,
    input  logic [4:0]  f_cu_rs2_addr_i,
    input  logic        f_cu_rs2_req_i,
    input  logic [4:0]  f_cu_rd_addr_i,
    input  logic        f_cu_rd_we_i,
    input  logic        f_cu_fence_i,
    input  logic        d_valid_i,
    input  logic        d_gpr_wr_en_i,
    input  logic [4:0]  d_gpr_wr_addr_i,
    input  logic        e_stall_req_i,
    input  logic        m_stall_req_i,
    input  logic        e_redirect_i,
    input  logic        m_gpr_wr_en_i,
    input  logic [4:0]  m_gpr_wr_addr_i,
    output logic        cu_stall_f_o,
    output logic        cu_stall_d_o,
    output logic        cu_kill_f_o,
    output logic        cu_kill_d_o,
    output logic        cu_busy_o
`ifdef MIRISCV_CU_PERF_CNT_EN
    ,
    output logic [31:0] cu_raw_stall_cnt_o,
    output logic [31:0] cu_flush_cnt_o,
    output logic [31:0] cu_drain_cnt_o
`endif
);
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t state, state_nxt;
    logic   fence_ok, fence_ok_nxt;

    logic [GPR_NUM-1:0][PEND_CNT_W-1:0] cnt;
    logic [GPR_NUM-1:0]                 inc_vec, dec_wb_vec, dec_kill_vec;

    logic raw, sat, hazard, fence_go, issue, inc, dec_wb, dec_kill, drain_done;

    assign raw    = (f_cu_rs1_req_i & (|cnt[f_cu_rs1_addr_i]))
                  | (f_cu_rs2_req_i & (|cnt[f_cu_rs2_addr_i]));
    assign sat    = f_cu_rd_we_i & (&cnt[f_cu_rd_addr_i]);
    assign hazard = f_valid_i & (raw | sat);

    // fence_ok lets the FENCE through once after a completed drain instead of re-entering DRAIN
    assign fence_go   = f_valid_i & f_cu_fence_i & ~fence_ok & (state == RUN);
    assign drain_done = ~cu_busy_o & ~d_valid_i;

    assign issue    = f_valid_i & ~cu_stall_f_o & ~cu_stall_d_o & ~cu_kill_f_o;
    assign inc      = issue & f_cu_rd_we_i & (f_cu_rd_addr_i != 5'd0);
    assign dec_wb   = m_gpr_wr_en_i & (m_gpr_wr_addr_i != 5'd0);
    assign dec_kill = cu_kill_d_o & d_valid_i & d_gpr_wr_en_i & (d_gpr_wr_addr_i != 5'd0);

    genvar r;
    generate
        for (r = 0; r < GPR_NUM; r++) begin : g_sb
            assign inc_vec[r]      = inc      & (f_cu_rd_addr_i  == 5'(r));
            assign dec_wb_vec[r]   = dec_wb   & (m_gpr_wr_addr_i == 5'(r));
            assign dec_kill_vec[r] = dec_kill & (d_gpr_wr_addr_i == 5'(r));
            if (r == 0) begin : g_x0
                assign cnt[r] = '0;
            end else begin : g_cnt
                miriscv_cu_pend_cnt #(.PEND_CNT_W(PEND_CNT_W)) u_cnt (
                    .clk_i    (clk_i),
                    .arstn_i  (arstn_i),
                    .inc      (inc_vec[r]),
                    .dec_wb   (dec_wb_vec[r]),
                    .dec_kill (dec_kill_vec[r]),
                    .cnt      (cnt[r])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state    <= RUN;
            fence_ok <= 1'b0;
        end else begin
            state    <= state_nxt;
            fence_ok <= fence_ok_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fence_ok_nxt = fence_ok;
        case (state)
            RUN: begin
                if (fence_go & ~cu_stall_d_o & ~cu_kill_f_o) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (e_redirect_i) begin
                    state_nxt = RUN;
                end else if (drain_done) begin
                    state_nxt    = RUN;
                    fence_ok_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (issue | e_redirect_i) fence_ok_nxt = 1'b0;
    end

    always_comb begin
        cu_stall_d_o = e_stall_req_i | m_stall_req_i;
        cu_kill_f_o  = e_redirect_i;
        cu_kill_d_o  = e_redirect_i;
        cu_busy_o    = |cnt;
        cu_stall_f_o = cu_stall_d_o | hazard | fence_go | (state == DRAIN);
    end

`ifdef MIRISCV_CU_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cu_raw_stall_cnt_o <= '0;
            cu_flush_cnt_o     <= '0;
            cu_drain_cnt_o     <= '0;
        end else begin
            if (hazard)           cu_raw_stall_cnt_o <= cu_raw_stall_cnt_o + 32'd1;
            if (e_redirect_i)     cu_flush_cnt_o     <= cu_flush_cnt_o + 32'd1;
            if (state == DRAIN)   cu_drain_cnt_o     <= cu_drain_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_miriscv_pipeline_cu.sv
// Directed table-driven bench for miriscv_pipeline_cu plus an async-reset-in-DRAIN sequence.

module tb_miriscv_pipeline_cu;
    logic       clk, arstn;
    logic       f_valid, rs1_req, rs2_req, rd_we, fence;
    logic [4:0] rs1, rs2, rd, d_addr, m_addr;
    logic       d_valid, d_we, e_stall, m_stall, redir, m_we;
    logic       stall_f, stall_d, kill_f, kill_d, busy;
`ifdef MIRISCV_CU_PERF_CNT_EN
    logic [31:0] raw_cnt, flush_cnt, drain_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    miriscv_pipeline_cu dut (
        .clk_i           (clk),
        .arstn_i         (arstn),
        .f_valid_i       (f_valid),
        .f_cu_rs1_addr_i (rs1),
        .f_cu_rs1_req_i  (rs1_req),
        .f_cu_rs2_addr_i (rs2),
        .f_cu_rs2_req_i  (rs2_req),
        .f_cu_rd_addr_i  (rd),
        .f_cu_rd_we_i    (rd_we),
        .f_cu_fence_i    (fence),
        .d_valid_i       (d_valid),
        .d_gpr_wr_en_i   (d_we),
        .d_gpr_wr_addr_i (d_addr),
        .e_stall_req_i   (e_stall),
        .m_stall_req_i   (m_stall),
        .e_redirect_i    (redir),
        .m_gpr_wr_en_i   (m_we),
        .m_gpr_wr_addr_i (m_addr),
        .cu_stall_f_o    (stall_f),
        .cu_stall_d_o    (stall_d),
        .cu_kill_f_o     (kill_f),
        .cu_kill_d_o     (kill_d),
        .cu_busy_o       (busy)
`ifdef MIRISCV_CU_PERF_CNT_EN
        ,
        .cu_raw_stall_cnt_o (raw_cnt),
        .cu_flush_cnt_o     (flush_cnt),
        .cu_drain_cnt_o     (drain_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fv;
        logic [4:0] rs1;
        logic       r1q;
        logic [4:0] rs2;
        logic       r2q;
        logic [4:0] rd;
        logic       we;
        logic       fence;
        logic       dv;
        logic       dwe;
        logic [4:0] dad;
        logic       es;
        logic       ms;
        logic       redir;
        logic       mwe;
        logic [4:0] mad;
        logic [4:0] exp;   // {stall_f, stall_d, kill_f, kill_d, busy}
    } vec_t;

    localparam int NVEC = 39;
    vec_t tbl [NVEC];

    function automatic vec_t mk(int fv, int a1, int q1, int a2, int q2, int ad, int we, int fc,
                                int dv, int dwe, int dad, int es, int ms, int rdr,
                                int mwe, int mad, int ex);
        vec_t v;
        v.fv = fv[0];   v.rs1 = a1[4:0];  v.r1q = q1[0]; v.rs2 = a2[4:0]; v.r2q = q2[0];
        v.rd = ad[4:0]; v.we = we[0];     v.fence = fc[0];
        v.dv = dv[0];   v.dwe = dwe[0];   v.dad = dad[4:0];
        v.es = es[0];   v.ms = ms[0];     v.redir = rdr[0];
        v.mwe = mwe[0]; v.mad = mad[4:0]; v.exp = ex[4:0];
        return v;
    endfunction

    task automatic drive(input vec_t v);
        f_valid = v.fv;  rs1 = v.rs1; rs1_req = v.r1q; rs2 = v.rs2; rs2_req = v.r2q;
        rd = v.rd;       rd_we = v.we; fence = v.fence;
        d_valid = v.dv;  d_we = v.dwe; d_addr = v.dad;
        e_stall = v.es;  m_stall = v.ms; redir = v.redir;
        m_we = v.mwe;    m_addr = v.mad;
    endtask

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {stall_f, stall_d, kill_f, kill_d, busy};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {sf,sd,kf,kd,busy}=%b expected %b", name, act, exp);
    endtask

    initial begin
        // RAW on x5 released by writeback
        tbl[0]  = mk(1,0,0,0,0, 5,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[1]  = mk(1,5,1,0,0, 6,1,0, 0,0,0, 0,0,0, 0,0, 'b10001);
        tbl[2]  = mk(1,5,1,0,0, 6,1,0, 0,0,0, 0,0,0, 0,0, 'b10001);
        tbl[3]  = mk(1,5,1,0,0, 6,1,0, 0,0,0, 0,0,0, 1,5, 'b10001);
        tbl[4]  = mk(1,5,1,0,0, 6,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[5]  = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,6, 'b00001);
        // saturation on x7 (max 3 in flight)
        tbl[6]  = mk(1,0,0,0,0, 7,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[7]  = mk(1,0,0,0,0, 7,1,0, 0,0,0, 0,0,0, 0,0, 'b00001);
        tbl[8]  = mk(1,0,0,0,0, 7,1,0, 0,0,0, 0,0,0, 0,0, 'b00001);
        tbl[9]  = mk(1,0,0,0,0, 7,1,0, 0,0,0, 0,0,0, 0,0, 'b10001);
        tbl[10] = mk(1,0,0,0,0, 7,1,0, 0,0,0, 0,0,0, 1,7, 'b10001);
        tbl[11] = mk(1,0,0,0,0, 7,1,0, 0,0,0, 0,0,0, 0,0, 'b00001);
        tbl[12] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,7, 'b00001);
        tbl[13] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,7, 'b00001);
        tbl[14] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,7, 'b00001);
        // same-cycle inc/dec on x3, then x0 traffic
        tbl[15] = mk(1,0,0,0,0, 3,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[16] = mk(1,0,0,0,0, 3,1,0, 0,0,0, 0,0,0, 1,3, 'b00001);
        tbl[17] = mk(1,0,1,0,0, 0,1,0, 0,0,0, 0,0,0, 0,0, 'b00001);
        tbl[18] = mk(1,0,0,3,1, 0,0,0, 0,0,0, 0,0,0, 0,0, 'b10001);
        tbl[19] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,3, 'b00001);
        tbl[20] = mk(1,0,0,3,1, 0,0,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        // redirect under execute stall kills decode write to x9
        tbl[21] = mk(1,0,0,0,0, 9,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[22] = mk(1,0,0,0,0,10,1,0, 1,1,9, 1,0,1, 0,0, 'b11111);
        tbl[23] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        // FENCE drain with x4 pending
        tbl[24] = mk(1,0,0,0,0, 4,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[25] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b10001);
        tbl[26] = mk(1,0,0,0,0, 0,0,1, 1,0,0, 0,0,0, 0,0, 'b10001);
        tbl[27] = mk(1,0,0,0,0, 0,0,1, 1,0,0, 0,0,0, 1,4, 'b10001);
        tbl[28] = mk(1,0,0,0,0, 0,0,1, 1,0,0, 0,0,0, 0,0, 'b10000);
        tbl[29] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b10000);
        tbl[30] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b00000);
        // next FENCE drains again; redirect aborts the drain
        tbl[31] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b10000);
        tbl[32] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,1, 0,0, 'b10110);
        tbl[33] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b10000);
        tbl[34] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 'b10000);
        // two writes to x6, then enter DRAIN for the reset sequence
        tbl[35] = mk(1,0,0,0,0, 6,1,0, 0,0,0, 0,0,0, 0,0, 'b00000);
        tbl[36] = mk(1,0,0,0,0, 6,1,0, 0,0,0, 0,0,0, 0,0, 'b00001);
        tbl[37] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b10001);
        tbl[38] = mk(1,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 0,0, 'b10001);

        arstn = 1'b0;
        drive(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0));
        #1 chk("reset", 5'b00000);
        @(negedge clk) arstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1 chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // async reset while in DRAIN with cnt[6]=2
        @(negedge clk);
        drive(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0));
        #1 chk("drain_pre_rst", 5'b10001);
        #1 arstn = 1'b0;
        #1 chk("drain_async_rst", 5'b00000);
        @(negedge clk) arstn = 1'b1;
        #1 chk("post_rst_idle", 5'b00000);
        @(negedge clk);
        drive(mk(1,6,1,6,1, 0,0,0, 0,0,0, 0,0,0, 0,0, 0));
        #1 chk("post_rst_x6_clear", 5'b00000);
        @(negedge clk);
        drive(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0, 0,0, 0));
        #1 chk("m_stall", 5'b11000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
